crc_engine: RTL and testbench

Parametrised, streaming CRC/LFSR engine. Generalises the fixed 8-bit feedback register to any CRC width and polynomial, with configurable init value, final XOR, input/output bit reflection, data width and bits processed per cycle. It takes data words over a valid/ready stream with a last flag and returns the finished CRC over a valid/ready result port. It sits beside peripherals such as UART or SPI for frame checking, and is also used standalone as a checksum accelerator.

---
 rtl/crc_pkg.sv | 33 +++
 rtl/crc_step.sv | 25 ++
 rtl/crc_engine.sv | 133 +++++++++++++
 tb/tb_crc_engine.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared types and helpers for the CRC engine
// Contents: crc_state_e FSM encoding, cnt_width() counter sizing, bitrev() register reversal.

package crc_pkg;

    typedef enum logic [1:0] {
        Idle   = 2'd0,
        Shift  = 2'd1,
        Result = 2'd2
    } crc_state_e;

    // Widest CRC register bitrev() can reverse.
    localparam int unsigned CrcMaxWidth = 64;

    // Shift counter width: $clog2(n) bits, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Reverse the low w bits of v; bits at and above w come back zero.
    function automatic logic [CrcMaxWidth-1:0] bitrev(input logic [CrcMaxWidth-1:0] v,
                                                      input int unsigned          w);
        logic [CrcMaxWidth-1:0] r;
        r = '0;
        for (int i = 0; i < CrcMaxWidth; i++) begin
            if (i < int'(w)) begin
                r[int'(w) - 1 - i] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_step.sv
// rtl/crc_step.sv - combinational fold of BitsPerCycle input bits into a CRC register
// Ports: crc_i current CRC, bits_i bits to fold (bits_i[BitsPerCycle-1] is folded first),
//        crc_o CRC after all bits are applied.

module crc_step #(
    parameter int unsigned          CrcWidth     = 8,
    parameter logic [CrcWidth-1:0]  Poly         = 8'h07,
    parameter int unsigned          BitsPerCycle = 8
) (
    input  logic [CrcWidth-1:0]     crc_i,
    input  logic [BitsPerCycle-1:0] bits_i,
    output logic [CrcWidth-1:0]     crc_o
);

    always_comb begin
        logic [CrcWidth-1:0] c;
        c = crc_i;
        // Serial LFSR steps unrolled, oldest input bit first.
        for (int i = BitsPerCycle - 1; i >= 0; i--) begin
            c = {c[CrcWidth-2:0], 1'b0} ^ ((c[CrcWidth-1] ^ bits_i[i]) ? Poly : '0);
        end
        crc_o = c;
    end

endmodule

// File: rtl/crc_engine.sv
// rtl/crc_engine.sv - parametrised streaming CRC engine with valid/ready data and result ports
// Ports: clk_i, rst_i (async, active high), clear_i (sync abort),
//        data_valid_i/data_ready_o/data_i/data_last_i input word stream,
//        crc_valid_o/crc_ready_i/crc_o result stream, busy_o (engine not idle).

module crc_engine
    import crc_pkg::*;
#(
    parameter int unsigned          CrcWidth     = 8,
    parameter logic [CrcWidth-1:0]  Poly         = 8'h07,
    parameter logic [CrcWidth-1:0]  InitVal      = 8'h00,
    parameter logic [CrcWidth-1:0]  XorOut       = 8'h00,
    parameter int unsigned          DataWidth    = 8,
    parameter int unsigned          BitsPerCycle = 8,
    parameter bit                   ReflectIn    = 1'b0,
    parameter bit                   ReflectOut   = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 data_last_i,
    output logic                 crc_valid_o,
    input  logic                 crc_ready_i,
    output logic [CrcWidth-1:0]  crc_o,
    output logic                 busy_o
);

    localparam int unsigned    ShiftsPerWord = DataWidth / BitsPerCycle;
    localparam int unsigned    CntWidth      = cnt_width(ShiftsPerWord);
    localparam logic [CntWidth-1:0] LastCnt  = CntWidth'(ShiftsPerWord - 1);

    crc_state_e             state_q;
    logic [CrcWidth-1:0]    crc_q;
    logic [DataWidth-1:0]   sreg_q;
    logic [CntWidth-1:0]    cnt_q;
    logic                   last_q;
    logic                   data_ready_q;
    logic                   crc_valid_q;
    logic                   busy_q;

    logic [DataWidth-1:0]   stream_in;
    logic [CrcWidth-1:0]    crc_next;
    logic [CrcWidth-1:0]    crc_rev;

    // Put the word in feed order, first bit at the MSB. Byte 0 first with each
    // byte LSB first is exactly a full bit reversal of the word.
    for (genvar i = 0; i < DataWidth; i++) begin : g_stream
        assign stream_in[i] = ReflectIn ? data_i[DataWidth-1-i] : data_i[i];
    end

    crc_step #(
        .CrcWidth     (CrcWidth),
        .Poly         (Poly),
        .BitsPerCycle (BitsPerCycle)
    ) u_crc_step (
        .crc_i  (crc_q),
        .bits_i (sreg_q[DataWidth-1 -: BitsPerCycle]),
        .crc_o  (crc_next)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= Idle;
            crc_q        <= InitVal;
            sreg_q       <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            data_ready_q <= 1'b1;
            crc_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else if (clear_i) begin
            // Abort wins over any handshake presented in the same cycle.
            state_q      <= Idle;
            crc_q        <= InitVal;
            data_ready_q <= 1'b1;
            crc_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                Idle: begin
                    if (data_valid_i && data_ready_q) begin
                        sreg_q       <= stream_in;
                        last_q       <= data_last_i;
                        cnt_q        <= '0;
                        state_q      <= Shift;
                        data_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                Shift: begin
                    crc_q  <= crc_next;
                    sreg_q <= sreg_q << BitsPerCycle;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        if (last_q) begin
                            state_q     <= Result;
                            crc_valid_q <= 1'b1;
                        end else begin
                            state_q      <= Idle;
                            data_ready_q <= 1'b1;
                            busy_q       <= 1'b0;
                        end
                    end
                end
                Result: begin
                    if (crc_ready_i) begin
                        crc_q        <= InitVal;
                        state_q      <= Idle;
                        crc_valid_q  <= 1'b0;
                        data_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= Idle;
                    data_ready_q <= 1'b1;
                    crc_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign crc_rev      = CrcWidth'(bitrev(CrcMaxWidth'(crc_q), CrcWidth));
    assign crc_o        = (ReflectOut ? crc_rev : crc_q) ^ XorOut;
    assign data_ready_o = data_ready_q;
    assign crc_valid_o  = crc_valid_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_crc_engine.sv
// tb/tb_crc_engine.sv - self-checking bench for crc_engine across four parameter sets

module tb_crc_engine;

    typedef logic [15:0] word_q_t[$];

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        clear = 1'b0;
    logic        dv    = 1'b0;
    logic        last  = 1'b0;
    logic        cr    = 1'b0;
    logic [15:0] din   = '0;
    logic [1:0]  sel   = 2'd0;

    int tests = 0;
    int fails = 0;

    logic [3:0]  dv_v, cr_v, rdy, cv, bz;
    logic [7:0]  c8;
    logic [31:0] c32;
    logic [15:0] c16;
    logic [11:0] c12;

    logic        cur_rdy, cur_cv, cur_busy;
    logic [31:0] cur_crc;

    // Configuration table for the reference model, indexed like sel.
    int              cw    [4] = '{8, 32, 16, 12};
    longint unsigned cpoly [4] = '{64'h07, 64'h04C11DB7, 64'h1021, 64'h80F};
    longint unsigned cinit [4] = '{64'h00, 64'hFFFFFFFF, 64'hFFFF, 64'hABC};
    longint unsigned cxor  [4] = '{64'h00, 64'hFFFFFFFF, 64'h0000, 64'h123};
    bit              rin   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit              rout  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int              cdw   [4] = '{8, 8, 8, 16};

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_sel
        assign dv_v[k] = dv && (sel == 2'(k));
        assign cr_v[k] = cr && (sel == 2'(k));
    end

    crc_engine u_crc8 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .data_valid_i(dv_v[0]), .data_ready_o(rdy[0]), .data_i(din[7:0]), .data_last_i(last),
        .crc_valid_o(cv[0]), .crc_ready_i(cr_v[0]), .crc_o(c8), .busy_o(bz[0])
    );

    crc_engine #(
        .CrcWidth(32), .Poly(32'h04C11DB7), .InitVal(32'hFFFFFFFF), .XorOut(32'hFFFFFFFF),
        .DataWidth(8), .BitsPerCycle(8), .ReflectIn(1'b1), .ReflectOut(1'b1)
    ) u_crc32 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .data_valid_i(dv_v[1]), .data_ready_o(rdy[1]), .data_i(din[7:0]), .data_last_i(last),
        .crc_valid_o(cv[1]), .crc_ready_i(cr_v[1]), .crc_o(c32), .busy_o(bz[1])
    );

    crc_engine #(
        .CrcWidth(16), .Poly(16'h1021), .InitVal(16'hFFFF), .XorOut(16'h0000),
        .DataWidth(8), .BitsPerCycle(1), .ReflectIn(1'b0), .ReflectOut(1'b0)
    ) u_crc16 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .data_valid_i(dv_v[2]), .data_ready_o(rdy[2]), .data_i(din[7:0]), .data_last_i(last),
        .crc_valid_o(cv[2]), .crc_ready_i(cr_v[2]), .crc_o(c16), .busy_o(bz[2])
    );

    crc_engine #(
        .CrcWidth(12), .Poly(12'h80F), .InitVal(12'hABC), .XorOut(12'h123),
        .DataWidth(16), .BitsPerCycle(4), .ReflectIn(1'b1), .ReflectOut(1'b1)
    ) u_crc12 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .data_valid_i(dv_v[3]), .data_ready_o(rdy[3]), .data_i(din), .data_last_i(last),
        .crc_valid_o(cv[3]), .crc_ready_i(cr_v[3]), .crc_o(c12), .busy_o(bz[3])
    );

    assign cur_rdy  = rdy[sel];
    assign cur_cv   = cv[sel];
    assign cur_busy = bz[sel];

    always_comb begin
        case (sel)
            2'd0:    cur_crc = {24'b0, c8};
            2'd1:    cur_crc = c32;
            2'd2:    cur_crc = {16'b0, c16};
            default: cur_crc = {20'b0, c12};
        endcase
    end

    // Textbook bitwise CRC over the message as a byte sequence.
    function automatic logic [31:0] model(input int s, input word_q_t q);
        logic [7:0]      bytes[$];
        longint unsigned crc, mask, r;
        int              w;
        w    = cw[s];
        mask = (64'd1 << w) - 1;
        foreach (q[i]) begin
            if (cdw[s] == 16) begin
                if (rin[s]) begin
                    bytes.push_back(q[i][7:0]);
                    bytes.push_back(q[i][15:8]);
                end else begin
                    bytes.push_back(q[i][15:8]);
                    bytes.push_back(q[i][7:0]);
                end
            end else begin
                bytes.push_back(q[i][7:0]);
            end
        end
        crc = cinit[s];
        foreach (bytes[i]) begin
            for (int j = 0; j < 8; j++) begin
                bit b, fb;
                b   = rin[s] ? bytes[i][j] : bytes[i][7-j];
                fb  = crc[w-1] ^ b;
                crc = ((crc << 1) & mask) ^ (fb ? cpoly[s] : 64'd0);
            end
        end
        if (rout[s]) begin
            r = 0;
            for (int j = 0; j < w; j++) r[j] = crc[w-1-j];
            crc = r;
        end
        return 32'(crc ^ cxor[s]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] w, input logic l);
        int k;
        k = 0;
        while (cur_rdy !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k == 200) check("ready_timeout", {31'b0, cur_rdy}, 32'd1);
        dv = 1'b1; din = w; last = l;
        @(negedge clk);
        dv = 1'b0; last = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (cur_cv !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid"}, {31'b0, cur_cv}, 32'd1);
    endtask

    task automatic take_result(input logic [31:0] exp, input string tag);
        wait_valid(tag);
        check(tag, cur_crc, exp);
        cr = 1'b1;
        @(negedge clk);
        cr = 1'b0;
        check({tag, "_idle"}, {29'b0, cur_busy, cur_rdy, cur_cv}, 32'b010);
    endtask

    task automatic send_all(input word_q_t q);
        foreach (q[i]) send_word(q[i], i == q.size() - 1);
    endtask

    task automatic run_frame(input word_q_t q, input logic [31:0] exp, input string tag);
        send_all(q);
        take_result(exp, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_q_t msg, q;
        int      k;
        msg = '{16'h31, 16'h32, 16'h33, 16'h34, 16'h35, 16'h36, 16'h37, 16'h38, 16'h39};

        // Reset state of all four engines.
        repeat (2) @(negedge clk);
        check("reset_rdy", {28'b0, rdy}, 32'hF);
        check("reset_cv",  {28'b0, cv},  32'h0);
        check("reset_bz",  {28'b0, bz},  32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Standard check values.
        sel = 2'd0;
        run_frame(msg, 32'hF4, "crc8_check");
        sel = 2'd1;
        run_frame(msg, 32'hCBF43926, "crc32_check");

        // CRC-16 bit-serial: 8 shift cycles per byte, then the check value.
        sel = 2'd2;
        send_word(16'h31, 1'b0);
        check("crc16_busy", {31'b0, cur_busy}, 32'd1);
        k = 0;
        while (cur_rdy !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("crc16_shift_cycles", k, 8);
        q = msg;
        void'(q.pop_front());
        run_frame(q, 32'h29B1, "crc16_check");

        // CRC-8 single shift cycle per word.
        sel = 2'd0;
        send_word(16'h31, 1'b0);
        k = 0;
        while (cur_rdy !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("crc8_shift_cycles", k, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        // Back-pressure: result held stable for 10 cycles, then reload proven by a second frame.
        send_all(msg);
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_crc", cur_crc, 32'hF4);
            check("bp_flags", {30'b0, cur_cv, cur_rdy}, 32'b10);
        end
        take_result(32'hF4, "bp_release");
        run_frame(msg, 32'hF4, "bp_second");

        // Clear during the shift of the 5th byte.
        for (int i = 0; i < 5; i++) send_word(msg[i], 1'b0);
        check("clr_in_shift", {31'b0, cur_busy}, 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_idle", {29'b0, cur_busy, cur_rdy, cur_cv}, 32'b010);
        // A handshake alongside clear is dropped.
        clear = 1'b1; dv = 1'b1; din = 16'hAA; last = 1'b1;
        @(negedge clk);
        clear = 1'b0; dv = 1'b0; last = 1'b0;
        check("clr_hs_ignored", {29'b0, cur_busy, cur_rdy, cur_cv}, 32'b010);
        run_frame(msg, 32'hF4, "clr_frame");

        // Clear in mid-shift of a bit-serial word, and clear while a result is pending.
        sel = 2'd2;
        send_word(16'h31, 1'b0);
        send_word(16'h32, 1'b0);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr16_idle", {29'b0, cur_busy, cur_rdy, cur_cv}, 32'b010);
        run_frame(msg, 32'h29B1, "clr16_frame");
        sel = 2'd0;
        send_all(msg);
        wait_valid("clr_res");
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_res_drop", {29'b0, cur_busy, cur_rdy, cur_cv}, 32'b010);
        run_frame(msg, 32'hF4, "clr_res_frame");

        // Reset pulse mid-frame.
        for (int i = 0; i < 3; i++) send_word(msg[i], 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid", {29'b0, cur_busy, cur_rdy, cur_cv}, 32'b010);
        run_frame(msg, 32'hF4, "rst_frame");

        // Random frames on every configuration against the reference model.
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            for (int f = 0; f < 5; f++) begin
                int len;
                q.delete();
                len = $urandom_range(1, 6);
                for (int i = 0; i < len; i++) begin
                    logic [15:0] w;
                    w = 16'($urandom);
                    if (cdw[s] == 8) w[15:8] = 8'h00;
                    q.push_back(w);
                end
                run_frame(q, model(s, q), $sformatf("rand_cfg%0d_f%0d", s, f));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
